dac_sample_scheduler: RTL and testbench
=======================================

Name: dac_sample_scheduler

Overview:
- Sample-rate scheduler and channel collector in front of the 4-channel DACx0004 SPI driver.
- Accepts per-channel signed samples from up to four independent producers via valid/ready, holds them in shadow registers, and commits all four at a programmable sample period.
- Each commit emits a one-cycle ce strobe to the driver.
- Enforces a minimum period so the driver's four serial frames always complete before the next ce, and flags per-channel overrun/underrun.

Parameters:
MIN_PERIOD, 1024, minimum clock cycles between ce pulses; covers 4 SPI frames plus sync gaps in the driver.
PERIOD_W, 16, width of the period input.

Ports:
clk100mhz  in  1  system clock
rstn  in  1  asynchronous active-low reset
i_enable  in  1  run scheduler; low forces IDLE
i_period  in  PERIOD_W  requested sample period in clock cycles
i4_mute  in  4  per-channel mute; muted channel commits signed 0 (DAC midscale)
i4_valid  in  4  per-channel sample valid
is16_sample_ch0..ch3  in  16 each  signed samples
o4_ready  out  4  per-channel ready
os16_data_ch0..ch3  out  16 each  committed signed samples to driver
o_ce  out  1  one-cycle commit strobe to driver
o4_overrun  out  4  sticky: second sample accepted before commit
o4_underrun  out  4  sticky: commit with no fresh sample on an unmuted channel
i_clear_status  in  1  synchronous clear of sticky flags

Behaviour:
- Reset (async, rstn low): state IDLE, counter 0, P = MIN_PERIOD, shadows 0, fresh 0, os16_data_* 0, o_ce 0, o4_ready 0, o4_overrun 0, o4_underrun 0.
- Effective period P = max(i_period, MIN_PERIOD). P is sampled on IDLE->COUNT and in every COMMIT cycle; changes in between are ignored.
- States:
  - IDLE: o4_ready = 0. If i_enable is high: counter <= P-2, go to COUNT.
  - COUNT: o4_ready = 4'hF. Counter decrements. At counter == 0, go to COMMIT.
  - COMMIT: lasts one cycle. o4_ready = 0. Reload counter <= P-2 and go to COUNT.
- In every state, i_enable low for a cycle gives IDLE on the next cycle, no ce, and clears fresh[3:0]. os16_data_* hold their values; shadows hold.
- o4_ready is decoded directly from state (combinational from the state register).
- Accept on channel n = i4_valid[n] & o4_ready[n]:
  - shadow[n] <= sample.
  - If fresh[n] was already set, set o4_overrun[n]; the newest sample wins.
  - fresh[n] <= 1.
- COMMIT cycle, evaluated per channel on its closing edge:
  - If mute: os16_data_n <= 0.
  - Else if fresh: os16_data_n <= shadow[n].
  - Else: hold os16_data_n and set o4_underrun[n].
  - fresh[n] <= 0 in all three cases.
  - o_ce <= 1 for exactly the next cycle, coincident with the new data.
  - No accept can coincide with the commit because ready is low.
- Timing:
  - First o_ce occurs P+1 cycles after the first cycle i_enable is sampled high.
  - Subsequent o_ce pulses are exactly P cycles apart.
  - os16_data_* change only on the edge that raises o_ce and stay stable for at least MIN_PERIOD cycles.
- Sticky flags: i_clear_status clears all flags. A set event in the same cycle wins over clear.
- Reset mid-operation: immediate return to reset values; a pulse in progress on o_ce is dropped.
- No arithmetic wrap: counter width is PERIOD_W; P-2 is never negative since MIN_PERIOD ≥ 2.

Test Plan:
1. Reset, i_period=2000, i_enable high at cycle 0, all channels valid once with 0x1234/0x8000/0x7FFF/0xFFFF -> o_ce at cycle 2001 and 4001; os16_data_* equal those values from cycle 2001; no flags set.
2. i_period=10 -> ce spacing clamps to 1024; change i_period to 3000 mid-COUNT -> next spacing still 1024, the following one 3000.
3. Two samples on ch1 (0x0100 then 0x0200) within one period, none on ch2 -> commit gives ch1=0x0200, o4_overrun=4'b0010; ch2 holds old value, o4_underrun=4'b0100. Assert i_clear_status together with a new overrun -> flag stays set.
4. i4_mute=4'b1000 with ch3 valid 0x5555 -> os16_data_ch3=0 at commit, no underrun on ch3 when later starved.
5. Hold valid high across a COMMIT -> ready low in that single cycle, accept on the next cycle; drop i_enable for one cycle mid-COUNT -> no ce, fresh cleared, restart timing P+1 from re-enable.
6. Assert rstn low while o_ce is high -> o_ce, data, and flags 0 immediately; o4_ready 0 until enable restarts.

Source files
------------

// File: rtl/dac_sample_scheduler_if.sv
// dac_sample_scheduler_if: producer-side sample handshake, control and committed-data bus of the scheduler.
interface dac_sample_scheduler_if #(parameter int PERIOD_W = 16);
  logic                i_enable;
  logic [PERIOD_W-1:0] i_period;
  logic [3:0]          i4_mute;
  logic [3:0]          i4_valid;
  logic signed [15:0]  is16_sample_ch0;
  logic signed [15:0]  is16_sample_ch1;
  logic signed [15:0]  is16_sample_ch2;
  logic signed [15:0]  is16_sample_ch3;
  logic                i_clear_status;
  logic [3:0]          o4_ready;
  logic signed [15:0]  os16_data_ch0;
  logic signed [15:0]  os16_data_ch1;
  logic signed [15:0]  os16_data_ch2;
  logic signed [15:0]  os16_data_ch3;
  logic                o_ce;
  logic [3:0]          o4_overrun;
  logic [3:0]          o4_underrun;
  modport master (
    output i_enable, i_period, i4_mute, i4_valid, i_clear_status,
           is16_sample_ch0, is16_sample_ch1, is16_sample_ch2, is16_sample_ch3,
    input  o4_ready, o_ce, o4_overrun, o4_underrun,
           os16_data_ch0, os16_data_ch1, os16_data_ch2, os16_data_ch3
  );
  modport slave (
    input  i_enable, i_period, i4_mute, i4_valid, i_clear_status,
           is16_sample_ch0, is16_sample_ch1, is16_sample_ch2, is16_sample_ch3,
    output o4_ready, o_ce, o4_overrun, o4_underrun,
           os16_data_ch0, os16_data_ch1, os16_data_ch2, os16_data_ch3
  );
endinterface

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: collects four channel samples into shadows and commits them together every P cycles with a ce strobe.
module dac_sample_scheduler #(
  parameter int MIN_PERIOD = 1024,
  parameter int PERIOD_W   = 16
) (
  input logic clk100mhz,
  input logic rstn,
  dac_sample_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  logic [1:0]          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, p_eff;
  logic [3:0][15:0]    shadow_q, shadow_d, data_q, data_d, sample;
  logic [3:0]          fresh_q, fresh_d, ovr_q, ovr_d, und_q, und_d, ready, acc;
  logic                ce_q, ce_d, commit;
  assign sample = {bus.is16_sample_ch3, bus.is16_sample_ch2, bus.is16_sample_ch1, bus.is16_sample_ch0};
  // The counter is loaded with P-2 so COUNT plus the single COMMIT cycle spans exactly P cycles.
  always_comb begin
    p_eff    = bus.i_period < MIN_P ? MIN_P : bus.i_period;
    ready    = state_q == COUNT ? 4'hF : 4'h0;
    acc      = bus.i4_valid & ready;
    commit   = bus.i_enable && state_q == COMMIT;
    state_d  = !bus.i_enable ? IDLE : state_q == COUNT ? (cnt_q == '0 ? COMMIT : COUNT) : COUNT;
    cnt_d    = !bus.i_enable ? cnt_q
             : state_q == COUNT ? (cnt_q == '0 ? cnt_q : cnt_q - PERIOD_W'(1))
             : p_eff - PERIOD_W'(2);
    fresh_d  = (!bus.i_enable || commit) ? 4'h0 : fresh_q | acc;
    ovr_d    = (bus.i_clear_status ? 4'h0 : ovr_q) | (acc & fresh_q);
    und_d    = (bus.i_clear_status ? 4'h0 : und_q) | ({4{commit}} & ~bus.i4_mute & ~fresh_q);
    ce_d     = commit;
    shadow_d = shadow_q;
    data_d   = data_q;
    for (int n = 0; n < 4; n++) begin
      shadow_d[n] = acc[n] ? sample[n] : shadow_q[n];
      data_d[n]   = !commit ? data_q[n] : bus.i4_mute[n] ? 16'h0 : fresh_q[n] ? shadow_q[n] : data_q[n];
    end
  end
  always_ff @(posedge clk100mhz or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      fresh_q  <= '0;
      ovr_q    <= '0;
      und_q    <= '0;
      ce_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      fresh_q  <= fresh_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
      ce_q     <= ce_d;
    end
  end
  assign bus.o4_ready      = ready;
  assign bus.o_ce          = ce_q;
  assign bus.o4_overrun    = ovr_q;
  assign bus.o4_underrun   = und_q;
  assign bus.os16_data_ch0 = data_q[0];
  assign bus.os16_data_ch1 = data_q[1];
  assign bus.os16_data_ch2 = data_q[2];
  assign bus.os16_data_ch3 = data_q[3];
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb_dac_sample_scheduler: scoreboard bench; each expected commit is queued when its samples are driven and checked at o_ce.
module tb_dac_sample_scheduler;
  logic clk100mhz = 1'b0;
  logic rstn = 1'b0;
  always #5 clk100mhz = ~clk100mhz;
  dac_sample_scheduler_if #(.PERIOD_W(16)) bus();
  dac_sample_scheduler #(.MIN_PERIOD(1024), .PERIOD_W(16)) dut (
    .clk100mhz(clk100mhz),
    .rstn(rstn),
    .bus(bus)
  );
  typedef struct {
    logic [63:0] d;
    logic [3:0]  ov;
    logic [3:0]  un;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, ce_seen = 0, next_cyc = 0;
  logic [3:0][15:0] m_sh, m_data;
  logic [3:0] m_fresh, m_ov, m_un;
  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic int eff(int p);
    return p < 1024 ? 1024 : p;
  endfunction
  always @(posedge clk100mhz or negedge rstn)
    if (!rstn) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clk100mhz) begin
    exp_t e;
    if (rstn && bus.o_ce) begin
      ce_seen++;
      if (sb.size() == 0) check("ce_unexpected", 64'(cyc), 64'(0));
      else begin
        e = sb.pop_front();
        check("ce_cycle", 64'(cyc), 64'(e.cyc));
        check("data", {bus.os16_data_ch3, bus.os16_data_ch2, bus.os16_data_ch1, bus.os16_data_ch0}, e.d);
        check("overrun", 64'(bus.o4_overrun), 64'(e.ov));
        check("underrun", 64'(bus.o4_underrun), 64'(e.un));
      end
    end
  end
  task automatic send(int ch, logic [15:0] v, logic clr = 1'b0);
    int k = 0;
    @(negedge clk100mhz);
    bus.i4_valid[ch] = 1'b1;
    bus.i_clear_status = clr;
    case (ch)
      0: bus.is16_sample_ch0 = v;
      1: bus.is16_sample_ch1 = v;
      2: bus.is16_sample_ch2 = v;
      default: bus.is16_sample_ch3 = v;
    endcase
    while (!bus.o4_ready[ch] && k < 50) begin
      @(negedge clk100mhz);
      k++;
    end
    if (k == 50) check("send_ready", 64'(bus.o4_ready[ch]), 64'(1));
    @(negedge clk100mhz);
    bus.i4_valid[ch] = 1'b0;
    bus.i_clear_status = 1'b0;
    if (clr) begin
      m_ov = '0;
      m_un = '0;
    end
    if (m_fresh[ch]) m_ov[ch] = 1'b1;
    m_fresh[ch] = 1'b1;
    m_sh[ch] = v;
  endtask
  task automatic send_all(logic [15:0] v0, logic [15:0] v1, logic [15:0] v2, logic [15:0] v3);
    send(0, v0);
    send(1, v1);
    send(2, v2);
    send(3, v3);
  endtask
  task automatic push(int at);
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      if (bus.i4_mute[n]) m_data[n] = 16'h0;
      else if (m_fresh[n]) m_data[n] = m_sh[n];
      else m_un[n] = 1'b1;
    end
    m_fresh = '0;
    e.d = m_data;
    e.ov = m_ov;
    e.un = m_un;
    e.cyc = at;
    sb.push_back(e);
  endtask
  task automatic wait_ce(int n);
    int k = 0;
    while (ce_seen < n && k < 4000) begin
      @(negedge clk100mhz);
      #1;
      k++;
    end
    if (ce_seen < n) check("ce_timeout", 64'(ce_seen), 64'(n));
  endtask
  initial begin
    bus.i_enable = 1'b0;
    bus.i_period = 16'd2000;
    bus.i4_mute = 4'h0;
    bus.i4_valid = 4'h0;
    bus.i_clear_status = 1'b0;
    bus.is16_sample_ch0 = '0;
    bus.is16_sample_ch1 = '0;
    bus.is16_sample_ch2 = '0;
    bus.is16_sample_ch3 = '0;
    m_sh = '0;
    m_data = '0;
    m_fresh = '0;
    m_ov = '0;
    m_un = '0;
    repeat (3) @(negedge clk100mhz);
    check("rst_ce", 64'(bus.o_ce), 64'(0));
    check("rst_ready", 64'(bus.o4_ready), 64'(0));
    check("rst_data", {bus.os16_data_ch3, bus.os16_data_ch2, bus.os16_data_ch1, bus.os16_data_ch0}, 64'(0));
    check("rst_ovr", 64'(bus.o4_overrun), 64'(0));
    check("rst_und", 64'(bus.o4_underrun), 64'(0));
    rstn = 1'b1;
    @(negedge clk100mhz);
    check("idle_ready", 64'(bus.o4_ready), 64'(0));
    bus.i_enable = 1'b1;
    next_cyc = cyc + 1 + 2000;
    send_all(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
    check("count_ready", 64'(bus.o4_ready), 64'hF);
    push(next_cyc);
    wait_ce(1);
    next_cyc += eff(int'(bus.i_period));
    send_all(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    push(next_cyc);
    wait_ce(2);
    next_cyc += eff(int'(bus.i_period));
    bus.i_period = 16'd10;
    send_all(16'h0011, 16'h0012, 16'h0013, 16'h0014);
    push(next_cyc);
    wait_ce(3);
    next_cyc += eff(int'(bus.i_period));
    send(0, 16'h0021);
    send(1, 16'h0100);
    send(1, 16'h0200);
    send(3, 16'h0024);
    bus.i_period = 16'd3000;
    push(next_cyc);
    wait_ce(4);
    next_cyc += eff(int'(bus.i_period));
    send(1, 16'h0300);
    send(1, 16'h0400, 1'b1);
    check("ovr_set_beats_clear", 64'(bus.o4_overrun), 64'(m_ov));
    check("und_cleared", 64'(bus.o4_underrun), 64'(m_un));
    send(0, 16'h0051);
    send(2, 16'h0053);
    send(3, 16'h0054);
    push(next_cyc);
    wait_ce(5);
    next_cyc += eff(int'(bus.i_period));
    bus.i4_mute = 4'b1000;
    send_all(16'h0031, 16'h0032, 16'h0033, 16'h5555);
    push(next_cyc);
    wait_ce(6);
    next_cyc += eff(int'(bus.i_period));
    send(0, 16'h0041);
    send(1, 16'h0042);
    send(2, 16'h0043);
    push(next_cyc);
    while (cyc < next_cyc - 1) @(negedge clk100mhz);
    bus.i4_valid[0] = 1'b1;
    bus.is16_sample_ch0 = 16'h0AAA;
    check("rdy_commit", 64'(bus.o4_ready[0]), 64'(0));
    @(negedge clk100mhz);
    check("rdy_after_commit", 64'(bus.o4_ready[0]), 64'(1));
    @(negedge clk100mhz);
    bus.i4_valid[0] = 1'b0;
    m_sh[0] = 16'h0AAA;
    m_fresh[0] = 1'b1;
    wait_ce(7);
    next_cyc += eff(int'(bus.i_period));
    send(1, 16'h0BBB);
    send(2, 16'h0CCC);
    @(negedge clk100mhz);
    bus.i_enable = 1'b0;
    @(negedge clk100mhz);
    check("rdy_disabled", 64'(bus.o4_ready), 64'(0));
    bus.i_enable = 1'b1;
    next_cyc = cyc + 1 + eff(int'(bus.i_period));
    m_fresh = '0;
    send(1, 16'h0DDD);
    push(next_cyc);
    wait_ce(8);
    next_cyc += eff(int'(bus.i_period));
    send_all(16'h0061, 16'h0062, 16'h0063, 16'h0064);
    push(next_cyc);
    while (cyc < next_cyc) @(negedge clk100mhz);
    #2;
    check("ce_before_rst", 64'(bus.o_ce), 64'(1));
    rstn = 1'b0;
    #1;
    check("rst_mid_ce", 64'(bus.o_ce), 64'(0));
    check("rst_mid_data", {bus.os16_data_ch3, bus.os16_data_ch2, bus.os16_data_ch1, bus.os16_data_ch0}, 64'(0));
    check("rst_mid_flags", 64'({bus.o4_overrun, bus.o4_underrun}), 64'(0));
    check("rst_mid_ready", 64'(bus.o4_ready), 64'(0));
    bus.i_enable = 1'b0;
    @(negedge clk100mhz);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk100mhz);
      check("rdy_after_rst", 64'(bus.o4_ready), 64'(0));
    end
    bus.i_enable = 1'b1;
    @(negedge clk100mhz);
    check("rdy_restart", 64'(bus.o4_ready), 64'hF);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
